// File: rtl/datapath_module.sv
// 16-bit single-cycle RISC datapath: PC, instruction/data memories, 8x16 register file,
// ALU with carry register, writeback/PC-update muxing and the OutR output register.
module datapath_module #(
   parameter int IMEM_AW = 8,
   parameter int DMEM_AW = 8
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        flag_HLT,
   input  logic        test_normal,
   input  logic        ext_instr_we,
   input  logic [15:0] ext_instr_addr,
   input  logic [15:0] ext_instr_data,
   input  logic        ext_data_write_en,
   input  logic [15:0] ext_data_addr,
   input  logic [15:0] ext_data_data,
   input  logic        data_write_en,
   input  logic        Src_Read_B,
   input  logic        Src_ALU_B,
   input  logic        ADC,
   input  logic        SUB,
   input  logic        SBB,
   input  logic        JMP,
   input  logic        BRANCH,
   input  logic        flag_label_PC,
   input  logic        flag_Rm_PC,
   input  logic        flag_Rd_PC,
   input  logic        flag_mem_RF,
   input  logic        flag_ALU_RF,
   input  logic        flag_Rm_RF,
   input  logic        flag_PC_RF,
   input  logic        LHI,
   input  logic        LLI,
   input  logic        RF_write_en,
   input  logic        flag_OutR,
   output logic [15:0] mem_instr_out,
   output logic        Pre_C,
   output logic        Pre_V,
   output logic        Pre_Z,
   output logic        Pre_N,
   output logic [15:0] OutR
);

   logic [15:0] imem [0:(1<<IMEM_AW)-1];
   logic [15:0] dmem [0:(1<<DMEM_AW)-1];
   logic [15:0] regs [0:7];

   logic [15:0] pc, pc_plus1, pc_next;
   logic        c_q;
   logic        running;
   logic [15:0] instr;
   logic [2:0]  rd, rn, rm, rb_sel;
   logic [15:0] port_a, port_b, alu_b, alu_b_eff, alu_res, mem_rdata, wb_data;
   logic [16:0] alu_sum;
   logic        alu_cin;
   logic        unused_bits;

   // Test mode freezes all architectural state; only the memories may change.
   assign running  = flag_HLT && !test_normal;

   assign instr         = imem[test_normal ? ext_instr_addr[IMEM_AW-1:0] : pc[IMEM_AW-1:0]];
   assign mem_instr_out = instr;

   assign rd     = instr[10:8];
   assign rn     = instr[7:5];
   assign rm     = instr[4:2];
   assign rb_sel = Src_Read_B ? rd : rm;
   assign port_a = regs[rn];
   assign port_b = regs[rb_sel];
   assign alu_b  = Src_ALU_B ? {11'd0, instr[4:0]} : port_b;

   // Subtracts invert B; the carry-in is 1 for SUB and the stored carry for ADC/SBB.
   always_comb begin
      alu_b_eff = alu_b;
      alu_cin   = 1'b0;
      if (ADC) begin
         alu_cin = c_q;
      end else if (SUB) begin
         alu_b_eff = ~alu_b;
         alu_cin   = 1'b1;
      end else if (SBB) begin
         alu_b_eff = ~alu_b;
         alu_cin   = c_q;
      end
   end

   assign alu_sum = {1'b0, port_a} + {1'b0, alu_b_eff} + {16'd0, alu_cin};
   assign alu_res = alu_sum[15:0];
   assign Pre_C   = alu_sum[16];
   assign Pre_V   = (port_a[15] == alu_b_eff[15]) && (alu_res[15] != port_a[15]);
   assign Pre_Z   = (alu_res == 16'd0);
   assign Pre_N   = alu_res[15];

   assign mem_rdata = dmem[alu_res[DMEM_AW-1:0]];
   assign pc_plus1  = pc + 16'd1;

   always_comb begin
      wb_data = 16'd0;
      if (LHI)              wb_data = {instr[7:0], port_b[7:0]};
      else if (LLI)         wb_data = {8'h00, instr[7:0]};
      else if (flag_mem_RF) wb_data = mem_rdata;
      else if (flag_ALU_RF) wb_data = alu_res;
      else if (flag_Rm_RF)  wb_data = port_b;
      else if (flag_PC_RF)  wb_data = pc_plus1;
   end

   always_comb begin
      pc_next = pc_plus1;
      if (JMP && (flag_Rm_PC || flag_Rd_PC))
         pc_next = port_b;
      else if (JMP && flag_label_PC)
         pc_next = pc_plus1 + {{5{instr[10]}}, instr[10:0]};
      else if (BRANCH)
         pc_next = pc_plus1 + {{8{instr[7]}}, instr[7:0]};
   end

   always_ff @(posedge clk) begin
      if (test_normal && ext_instr_we)
         imem[ext_instr_addr[IMEM_AW-1:0]] <= ext_instr_data;
   end

   always_ff @(posedge clk) begin
      if (test_normal) begin
         if (ext_data_write_en)
            dmem[ext_data_addr[DMEM_AW-1:0]] <= ext_data_data;
      end else if (flag_HLT && data_write_en) begin
         dmem[alu_res[DMEM_AW-1:0]] <= port_b;
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         for (int i = 0; i < 8; i++) regs[i] <= 16'd0;
      end else if (running && RF_write_en) begin
         regs[rd] <= wb_data;
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         pc   <= 16'd0;
         OutR <= 16'd0;
         c_q  <= 1'b0;
      end else if (running) begin
         pc <= pc_next;
         if (flag_OutR)
            OutR <= port_a;
         if (RF_write_en && flag_ALU_RF)
            c_q <= Pre_C;
      end
   end

   assign unused_bits = ^{instr[15:11], ext_instr_addr[15:IMEM_AW], ext_data_addr[15:DMEM_AW]};

endmodule

// File: tb/tb_datapath_module.sv
// Directed bench for datapath_module: preloads programs in test mode, then steps them
// one instruction at a time with hand-set control lines and hand-computed results.
module tb_datapath_module;

   logic        clk = 1'b0;
   logic        clr;
   logic        flag_HLT, test_normal;
   logic        ext_instr_we, ext_data_write_en;
   logic [15:0] ext_instr_addr, ext_instr_data, ext_data_addr, ext_data_data;
   logic        data_write_en, Src_Read_B, Src_ALU_B, ADC, SUB, SBB, JMP, BRANCH;
   logic        flag_label_PC, flag_Rm_PC, flag_Rd_PC;
   logic        flag_mem_RF, flag_ALU_RF, flag_Rm_RF, flag_PC_RF, LHI, LLI;
   logic        RF_write_en, flag_OutR;
   logic [15:0] mem_instr_out, OutR;
   logic        Pre_C, Pre_V, Pre_Z, Pre_N;

   int checks = 0;
   int errors = 0;

   datapath_module #(.IMEM_AW(8), .DMEM_AW(8)) dut (
      .clk(clk), .clr(clr), .flag_HLT(flag_HLT), .test_normal(test_normal),
      .ext_instr_we(ext_instr_we), .ext_instr_addr(ext_instr_addr), .ext_instr_data(ext_instr_data),
      .ext_data_write_en(ext_data_write_en), .ext_data_addr(ext_data_addr), .ext_data_data(ext_data_data),
      .data_write_en(data_write_en), .Src_Read_B(Src_Read_B), .Src_ALU_B(Src_ALU_B),
      .ADC(ADC), .SUB(SUB), .SBB(SBB), .JMP(JMP), .BRANCH(BRANCH),
      .flag_label_PC(flag_label_PC), .flag_Rm_PC(flag_Rm_PC), .flag_Rd_PC(flag_Rd_PC),
      .flag_mem_RF(flag_mem_RF), .flag_ALU_RF(flag_ALU_RF), .flag_Rm_RF(flag_Rm_RF),
      .flag_PC_RF(flag_PC_RF), .LHI(LHI), .LLI(LLI), .RF_write_en(RF_write_en),
      .flag_OutR(flag_OutR), .mem_instr_out(mem_instr_out),
      .Pre_C(Pre_C), .Pre_V(Pre_V), .Pre_Z(Pre_Z), .Pre_N(Pre_N), .OutR(OutR)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_ctrl();
      data_write_en = 0; Src_Read_B = 0; Src_ALU_B = 0; ADC = 0; SUB = 0; SBB = 0;
      JMP = 0; BRANCH = 0; flag_label_PC = 0; flag_Rm_PC = 0; flag_Rd_PC = 0;
      flag_mem_RF = 0; flag_ALU_RF = 0; flag_Rm_RF = 0; flag_PC_RF = 0; LHI = 0; LLI = 0;
      RF_write_en = 0; flag_OutR = 0; flag_HLT = 1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_imem(input logic [15:0] a, input logic [15:0] d);
      ext_instr_addr = a; ext_instr_data = d; ext_instr_we = 1;
      step();
      ext_instr_we = 0;
   endtask

   task automatic write_dmem(input logic [15:0] a, input logic [15:0] d);
      ext_data_addr = a; ext_data_data = d; ext_data_write_en = 1;
      step();
      ext_data_write_en = 0;
   endtask

   initial begin
      clr = 0; test_normal = 1;
      ext_instr_we = 0; ext_data_write_en = 0;
      ext_instr_addr = 0; ext_instr_data = 0; ext_data_addr = 0; ext_data_data = 0;
      clear_ctrl();
      #12;
      check_output("reset_pc", dut.pc, 16'h0000);
      check_output("reset_outr", OutR, 16'h0000);
      clr = 1;
      step();

      // Program 1: LDR, OutR, STR, LDR, OutR, BRANCH -2
      write_imem(16'd0, 16'h1900);
      write_imem(16'd1, 16'hE020);
      write_imem(16'd2, 16'h2901);
      write_imem(16'd3, 16'h1A01);
      write_imem(16'd4, 16'hE040);
      write_imem(16'd5, 16'h00FE);
      write_dmem(16'd0, 16'h1234);
      ext_instr_addr = 16'd1;
      #1;
      check_output("test_mode_imem_read", mem_instr_out, 16'hE020);

      test_normal = 0;
      #1;
      check_output("instr_at_pc0", mem_instr_out, 16'h1900);
      Src_ALU_B = 1; flag_mem_RF = 1; RF_write_en = 1;
      step();
      check_output("ldr_r1", dut.regs[1], 16'h1234);
      check_output("pc_after_ldr", dut.pc, 16'h0001);
      check_output("instr_at_pc1", mem_instr_out, 16'hE020);

      clear_ctrl(); flag_OutR = 1;
      step();
      check_output("outr_r1", OutR, 16'h1234);

      clear_ctrl(); Src_ALU_B = 1; Src_Read_B = 1; data_write_en = 1;
      step();
      check_output("str_dmem1", dut.dmem[1], 16'h1234);

      clear_ctrl(); Src_ALU_B = 1; flag_mem_RF = 1; RF_write_en = 1;
      step();
      check_output("ldr_r2", dut.regs[2], 16'h1234);

      clear_ctrl(); flag_OutR = 1;
      step();
      check_output("outr_r2", OutR, 16'h1234);
      check_output("pc_at_5", dut.pc, 16'h0005);

      // Halted: OutR would otherwise load R7 (=0) and PC would advance.
      clear_ctrl(); flag_HLT = 0; flag_OutR = 1; RF_write_en = 1; flag_PC_RF = 1;
      step();
      check_output("halt_pc", dut.pc, 16'h0005);
      check_output("halt_outr", OutR, 16'h1234);
      check_output("halt_r0", dut.regs[0], 16'h0000);

      clear_ctrl(); BRANCH = 1;
      step();
      check_output("branch_back", dut.pc, 16'h0004);

      // Program 2 loaded at PC=4; PC must not move while in test mode.
      clear_ctrl(); test_normal = 1;
      write_imem(16'd4,  16'h0156);
      write_imem(16'd5,  16'h0156);
      write_imem(16'd6,  16'h03FF);
      write_imem(16'd7,  16'h037F);
      write_imem(16'd8,  16'h0461);
      write_imem(16'd9,  16'h056C);
      write_imem(16'd10, 16'h0600);
      write_imem(16'd11, 16'h0770);
      write_imem(16'd12, 16'h0210);
      write_imem(16'd13, 16'h0008);
      write_imem(16'd16, 16'h0005);
      check_output("test_mode_pc_hold", dut.pc, 16'h0004);
      test_normal = 0;

      clear_ctrl(); LHI = 1; Src_Read_B = 1; RF_write_en = 1;
      step();
      check_output("lhi_r1", dut.regs[1], 16'h5634);

      clear_ctrl(); LLI = 1; RF_write_en = 1;
      step();
      check_output("lli_r1", dut.regs[1], 16'h0056);

      clear_ctrl(); LLI = 1; RF_write_en = 1;
      step();
      clear_ctrl(); LHI = 1; Src_Read_B = 1; RF_write_en = 1;
      step();
      check_output("r3_7fff", dut.regs[3], 16'h7FFF);

      clear_ctrl(); Src_ALU_B = 1; flag_ALU_RF = 1; RF_write_en = 1;
      #1;
      check_output("add_flags_VNCZ", {12'd0, Pre_V, Pre_N, Pre_C, Pre_Z}, 16'b1100);
      step();
      check_output("add_r4", dut.regs[4], 16'h8000);

      clear_ctrl(); SUB = 1; flag_ALU_RF = 1; RF_write_en = 1;
      #1;
      check_output("sub_flags_ZC", {14'd0, Pre_Z, Pre_C}, 16'b11);
      step();
      check_output("sub_r5", dut.regs[5], 16'h0000);

      clear_ctrl(); ADC = 1; Src_ALU_B = 1; flag_ALU_RF = 1; RF_write_en = 1;
      step();
      check_output("adc_r6", dut.regs[6], 16'h0001);

      clear_ctrl(); SBB = 1; flag_ALU_RF = 1; RF_write_en = 1;
      #1;
      check_output("sbb_flags_VNCZ", {12'd0, Pre_V, Pre_N, Pre_C, Pre_Z}, 16'b1100);
      step();
      check_output("sbb_r7", dut.regs[7], 16'hFFFE);

      clear_ctrl(); LLI = 1; RF_write_en = 1;
      step();
      clear_ctrl(); JMP = 1; flag_Rm_PC = 1;
      step();
      check_output("jmp_rm", dut.pc, 16'h0010);

      clear_ctrl(); JMP = 1; flag_label_PC = 1;
      step();
      check_output("jmp_label", dut.pc, 16'h0016);

      // Asynchronous clear away from any clock edge.
      clear_ctrl();
      clr = 0;
      #2;
      check_output("async_pc", dut.pc, 16'h0000);
      check_output("async_outr", OutR, 16'h0000);
      for (int i = 0; i < 8; i++)
         check_output($sformatf("async_r%0d", i), dut.regs[i], 16'h0000);
      clr = 1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
